// File: rtl/quad_wheel_gen_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : quad_wheel_gen_pkg                                         |
// | Brief   : Shared FSM states, phase table and defaults for the        |
// |           quadrature wheel-encoder emulator.                         |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
package quad_wheel_gen_pkg;

    // Must stay above the receiver's 1000-clock debounce window.
    localparam int unsigned MIN_PERIOD_DEFAULT = 1024;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_FINISH = 2'd2
    } state_t;

    // Forward walks {A,B} 11->01->00->10->11; backward is the exact reverse.
    function automatic logic [1:0] next_phase(input logic [1:0] phase,
                                              input logic       fwd);
        logic [1:0] nxt;
        nxt = phase;
        if (fwd) begin
            case (phase)
                2'b11:   nxt = 2'b01;
                2'b01:   nxt = 2'b00;
                2'b00:   nxt = 2'b10;
                default: nxt = 2'b11;
            endcase
        end else begin
            case (phase)
                2'b11:   nxt = 2'b10;
                2'b10:   nxt = 2'b00;
                2'b00:   nxt = 2'b01;
                default: nxt = 2'b11;
            endcase
        end
        return nxt;
    endfunction

endpackage
`default_nettype wire

// File: rtl/quad_wheel_gen_step_timer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : quad_step_timer                                            |
// | Brief   : Reloadable period down-counter with minimum-period clamp;  |
// |           one-cycle tick per elapsed period while running.           |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module quad_step_timer
    import quad_wheel_gen_pkg::*;
#(
    parameter int unsigned MIN_PERIOD = MIN_PERIOD_DEFAULT,
    parameter int unsigned PERIOD_W   = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                load,
    input  logic [PERIOD_W-1:0] period_in,
    input  logic                run,
    output logic                tick
);

    localparam logic [PERIOD_W-1:0] MIN_P = PERIOD_W'(MIN_PERIOD);

    logic [PERIOD_W-1:0] period_q;
    logic [PERIOD_W-1:0] count;
    logic [PERIOD_W-1:0] period_clamped;

    assign period_clamped = (period_in < MIN_P) ? MIN_P : period_in;

    // Loading period-1 makes the tick land exactly period cycles after load.
    assign tick = run && (count == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            period_q <= MIN_P;
            count    <= '0;
        end else if (load) begin
            period_q <= period_clamped;
            count    <= period_clamped - 1'b1;
        end else if (run) begin
            if (count == '0) begin
                count <= period_q - 1'b1;
            end else begin
                count <= count - 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/quad_wheel_gen.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : quad_wheel_gen                                             |
// | Brief   : Quadrature wheel-encoder emulator: executes move commands  |
// |           as A/B edge trains and tracks a signed edge position.      |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module quad_wheel_gen
    import quad_wheel_gen_pkg::*;
#(
    parameter int unsigned MIN_PERIOD = MIN_PERIOD_DEFAULT,
    parameter int unsigned PERIOD_W   = 16,
    parameter int unsigned STEPS_W    = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_cmd_valid,
    output logic                o_cmd_ready,
    input  logic                i_cmd_dir,
    input  logic [STEPS_W-1:0]  i_cmd_steps,
    input  logic [PERIOD_W-1:0] i_cmd_period,
    input  logic                i_abort,
    output logic                o_ch_a,
    output logic                o_ch_b,
    output logic                o_busy,
    output logic                o_done,
    output logic [31:0]         o_position
);

    state_t              state;
    state_t              state_next;
    logic                dir_q;
    logic                continuous;
    logic [STEPS_W-1:0]  steps_left;
    logic [1:0]          phase;
    logic [31:0]         position;

    logic                accept;
    logic                cmd_ready;
    logic                busy;
    logic                done;
    logic                running;
    logic                edge_fire;
    logic                last_edge;

    assign running   = (state == ST_RUN);
    assign last_edge = !continuous && (steps_left == STEPS_W'(1));

    quad_step_timer #(
        .MIN_PERIOD (MIN_PERIOD),
        .PERIOD_W   (PERIOD_W)
    ) u_timer (
        .clk       (clk),
        .rst       (rst),
        .load      (accept),
        .period_in (i_cmd_period),
        .run       (running),
        .tick      (edge_fire)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // An edge due in the same cycle as abort still fires; abort only blocks later edges.
    always_comb begin
        state_next = state;
        cmd_ready  = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        accept     = 1'b0;
        case (state)
            ST_IDLE: begin
                cmd_ready = 1'b1;
                if (i_cmd_valid) begin
                    accept     = 1'b1;
                    state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                busy = 1'b1;
                if (i_abort || (edge_fire && last_edge)) begin
                    state_next = ST_FINISH;
                end
            end
            ST_FINISH: begin
                busy       = 1'b1;
                done       = 1'b1;
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dir_q      <= 1'b0;
            continuous <= 1'b0;
            steps_left <= '0;
            phase      <= 2'b00;
            position   <= 32'd0;
        end else begin
            if (accept) begin
                dir_q      <= i_cmd_dir;
                steps_left <= i_cmd_steps;
                continuous <= (i_cmd_steps == '0);
            end
            // Phase persists across moves so consecutive moves stay continuous.
            if (edge_fire) begin
                phase <= next_phase(phase, dir_q);
                if (dir_q) begin
                    position <= position + 32'd1;
                end else begin
                    position <= position - 32'd1;
                end
                if (!continuous) begin
                    steps_left <= steps_left - 1'b1;
                end
            end
        end
    end

    assign o_cmd_ready = cmd_ready;
    assign o_busy      = busy;
    assign o_done      = done;
    assign o_ch_a      = phase[1];
    assign o_ch_b      = phase[0];
    assign o_position  = position;

endmodule
`default_nettype wire

// File: tb/tb_quad_wheel_gen.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : tb_quad_wheel_gen                                          |
// | Brief   : Directed self-checking bench for quad_wheel_gen.           |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module tb_quad_wheel_gen;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_dir;
    logic [15:0] cmd_steps;
    logic [15:0] cmd_period;
    logic        abort;
    logic        ch_a;
    logic        ch_b;
    logic        busy;
    logic        done;
    logic [31:0] position;

    int vecs = 0;
    int errs = 0;
    int cyc  = 0;

    // Observations gathered during a move
    int          etime [16];
    logic [1:0]  eab   [16];
    logic [31:0] epos  [16];
    int          ecnt;
    int          dcnt;
    int          dcyc;
    logic        rdy_at_done;
    logic        busy_at_done;
    logic        rdy_after;
    logic        busy_after;

    quad_wheel_gen dut (
        .clk          (clk),
        .rst          (rst),
        .i_cmd_valid  (cmd_valid),
        .o_cmd_ready  (cmd_ready),
        .i_cmd_dir    (cmd_dir),
        .i_cmd_steps  (cmd_steps),
        .i_cmd_period (cmd_period),
        .i_abort      (abort),
        .o_ch_a       (ch_a),
        .o_ch_b       (ch_b),
        .o_busy       (busy),
        .o_done       (done),
        .o_position   (position)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic send_cmd(input logic d, input logic [15:0] s,
                            input logic [15:0] p, output int acc);
        int n;
        n = 0;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_dir = d; cmd_steps = s; cmd_period = p;
        while (!cmd_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk); #1;
        acc = cyc;
        cmd_valid = 1'b0;
        vecs++;
        if (n >= 100) begin
            errs++;
            $display("FAIL accept_timeout got ready=%b exp ready=1", cmd_ready);
        end
    endtask

    // Record edges/done until done is seen plus four cycles, or the limit expires.
    task automatic watch(input int abort_after, input int abort_at, input int limit);
        logic [1:0] prev;
        int post;
        logic aborted;
        post = -1; aborted = 1'b0;
        ecnt = 0; dcnt = 0; dcyc = -1;
        rdy_at_done = 1'bx; busy_at_done = 1'bx; rdy_after = 1'bx; busy_after = 1'bx;
        for (int k = 0; k < 16; k++) begin
            etime[k] = -1; eab[k] = 2'bxx; epos[k] = 'x;
        end
        prev = {ch_a, ch_b};
        for (int n = 0; n < limit && post != 0; n++) begin
            @(posedge clk); #1;
            abort = 1'b0;
            if ({ch_a, ch_b} !== prev) begin
                if (ecnt < 16) begin
                    etime[ecnt] = cyc; eab[ecnt] = {ch_a, ch_b}; epos[ecnt] = position;
                end
                ecnt++;
                prev = {ch_a, ch_b};
            end
            if (done) begin
                dcnt++; dcyc = cyc; rdy_at_done = cmd_ready; busy_at_done = busy;
                post = 4;
            end else if (post > 0) begin
                if (cyc == dcyc + 1) begin
                    rdy_after = cmd_ready; busy_after = busy;
                end
                post--;
            end
            if (abort_after > 0 && ecnt == abort_after && !aborted) begin
                abort = 1'b1; aborted = 1'b1;
            end
            if (cyc == abort_at - 1) abort = 1'b1;
        end
        abort = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; cmd_valid = 1'b0; cmd_dir = 1'b0; cmd_steps = '0;
        cmd_period = '0; abort = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        vecs++;
        if ({ch_a, ch_b, busy, done, cmd_ready} !== 5'b00001) begin
            errs++;
            $display("FAIL reset_ctrl got ab/busy/done/ready=%b exp=00001",
                     {ch_a, ch_b, busy, done, cmd_ready});
        end
        vecs++;
        if (position !== 32'd0) begin
            errs++; $display("FAIL reset_pos got=%h exp=0", position);
        end
    endtask

    task automatic test_fwd_basic(inout logic [31:0] exp_pos);
        int acc;
        logic [1:0] exp_ab [4];
        exp_ab = '{2'b10, 2'b11, 2'b01, 2'b00};
        send_cmd(1'b1, 16'd4, 16'd2000, acc);
        vecs++;
        if (busy !== 1'b1 || cmd_ready !== 1'b0) begin
            errs++; $display("FAIL fwd_busy got busy=%b ready=%b exp 1/0", busy, cmd_ready);
        end
        watch(0, -1, 9000);
        vecs++;
        if (ecnt !== 4) begin errs++; $display("FAIL fwd_edges got=%0d exp=4", ecnt); end
        for (int i = 0; i < 4; i++) begin
            exp_pos = exp_pos + 32'd1;
            vecs++;
            if (etime[i] !== acc + 2000 * (i + 1) || eab[i] !== exp_ab[i] || epos[i] !== exp_pos) begin
                errs++;
                $display("FAIL fwd_edge%0d got t=%0d ab=%b pos=%h exp t=%0d ab=%b pos=%h",
                         i, etime[i] - acc, eab[i], epos[i], 2000 * (i + 1), exp_ab[i], exp_pos);
            end
        end
        vecs++;
        if (dcnt !== 1 || dcyc !== acc + 8000) begin
            errs++; $display("FAIL fwd_done got cnt=%0d t=%0d exp cnt=1 t=8000", dcnt, dcyc - acc);
        end
        vecs++;
        if (rdy_at_done !== 1'b0 || busy_at_done !== 1'b1 || rdy_after !== 1'b1 || busy_after !== 1'b0) begin
            errs++;
            $display("FAIL fwd_handshake got r/b@done=%b%b r/b@next=%b%b exp 01 10",
                     rdy_at_done, busy_at_done, rdy_after, busy_after);
        end
    endtask

    task automatic test_back_clamp(inout logic [31:0] exp_pos);
        int acc;
        logic [1:0] exp_ab [3];
        exp_ab = '{2'b01, 2'b11, 2'b10};
        send_cmd(1'b0, 16'd3, 16'd10, acc);
        watch(0, -1, 5000);
        vecs++;
        if (ecnt !== 3) begin errs++; $display("FAIL back_edges got=%0d exp=3", ecnt); end
        for (int i = 0; i < 3; i++) begin
            exp_pos = exp_pos - 32'd1;
            vecs++;
            if (etime[i] !== acc + 1024 * (i + 1) || eab[i] !== exp_ab[i] || epos[i] !== exp_pos) begin
                errs++;
                $display("FAIL back_edge%0d got t=%0d ab=%b pos=%h exp t=%0d ab=%b pos=%h",
                         i, etime[i] - acc, eab[i], epos[i], 1024 * (i + 1), exp_ab[i], exp_pos);
            end
        end
        vecs++;
        if (dcnt !== 1 || dcyc !== acc + 3072) begin
            errs++; $display("FAIL back_done got cnt=%0d t=%0d exp cnt=1 t=3072", dcnt, dcyc - acc);
        end
    endtask

    task automatic test_wrap(inout logic [31:0] exp_pos);
        int acc;
        send_cmd(1'b0, 16'd2, 16'd1024, acc);
        watch(0, -1, 4000);
        vecs++;
        if (ecnt !== 2 || eab[0] !== 2'b00 || epos[0] !== 32'd0) begin
            errs++; $display("FAIL wrap_first got n=%0d ab=%b pos=%h exp n=2 ab=00 pos=0",
                             ecnt, eab[0], epos[0]);
        end
        vecs++;
        if (eab[1] !== 2'b01 || epos[1] !== 32'hFFFF_FFFF) begin
            errs++; $display("FAIL wrap_pos got ab=%b pos=%h exp ab=01 pos=ffffffff", eab[1], epos[1]);
        end
        exp_pos = 32'hFFFF_FFFF;
    endtask

    task automatic test_continuous_abort(inout logic [31:0] exp_pos);
        int acc;
        logic [1:0] exp_ab [5];
        exp_ab = '{2'b00, 2'b10, 2'b11, 2'b01, 2'b00};
        send_cmd(1'b1, 16'd0, 16'd1024, acc);
        watch(5, -1, 9000);
        vecs++;
        if (ecnt !== 5) begin errs++; $display("FAIL cont_edges got=%0d exp=5", ecnt); end
        for (int i = 0; i < 5; i++) begin
            exp_pos = exp_pos + 32'd1;
            vecs++;
            if (etime[i] !== acc + 1024 * (i + 1) || eab[i] !== exp_ab[i] || epos[i] !== exp_pos) begin
                errs++;
                $display("FAIL cont_edge%0d got t=%0d ab=%b pos=%h exp t=%0d ab=%b pos=%h",
                         i, etime[i] - acc, eab[i], epos[i], 1024 * (i + 1), exp_ab[i], exp_pos);
            end
        end
        vecs++;
        if (dcnt !== 1 || dcyc !== etime[4] + 1) begin
            errs++; $display("FAIL cont_done got cnt=%0d t=%0d exp cnt=1 t=%0d", dcnt, dcyc, etime[4] + 1);
        end
        vecs++;
        if (rdy_at_done !== 1'b0 || rdy_after !== 1'b1) begin
            errs++; $display("FAIL cont_ready got @done=%b @next=%b exp 0 1", rdy_at_done, rdy_after);
        end
    endtask

    task automatic test_abort_on_edge(inout logic [31:0] exp_pos);
        int acc;
        send_cmd(1'b1, 16'd3, 16'd1024, acc);
        watch(0, acc + 2048, 5000);
        vecs++;
        if (ecnt !== 2 || eab[0] !== 2'b10 || eab[1] !== 2'b11) begin
            errs++; $display("FAIL abedge_edges got n=%0d ab=%b,%b exp n=2 ab=10,11", ecnt, eab[0], eab[1]);
        end
        exp_pos = exp_pos + 32'd2;
        vecs++;
        if (position !== exp_pos || etime[1] !== acc + 2048) begin
            errs++; $display("FAIL abedge_pos got pos=%h t=%0d exp pos=%h t=2048",
                             position, etime[1] - acc, exp_pos);
        end
        vecs++;
        if (dcnt !== 1 || dcyc !== acc + 2048) begin
            errs++; $display("FAIL abedge_done got cnt=%0d t=%0d exp cnt=1 t=2048", dcnt, dcyc - acc);
        end
    endtask

    task automatic test_back_to_back(inout logic [31:0] exp_pos);
        int acc1;
        int acc2;
        int n;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_dir = 1'b1; cmd_steps = 16'd1; cmd_period = 16'd1024;
        @(posedge clk); #1;
        acc1 = cyc;
        n = 0;
        while (!done && n < 3000) begin
            @(posedge clk); #1;
            n++;
        end
        exp_pos = exp_pos + 32'd1;
        vecs++;
        if (cyc !== acc1 + 1024 || {ch_a, ch_b} !== 2'b01 || position !== exp_pos) begin
            errs++; $display("FAIL b2b_first got t=%0d ab=%b pos=%h exp t=1024 ab=01 pos=%h",
                             cyc - acc1, {ch_a, ch_b}, position, exp_pos);
        end
        @(posedge clk); #1;
        vecs++;
        if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
            errs++; $display("FAIL b2b_idle got ready=%b busy=%b exp 1 0", cmd_ready, busy);
        end
        @(posedge clk); #1;
        acc2 = cyc;
        cmd_valid = 1'b0;
        vecs++;
        if (cmd_ready !== 1'b0 || busy !== 1'b1) begin
            errs++; $display("FAIL b2b_accept got ready=%b busy=%b exp 0 1", cmd_ready, busy);
        end
        watch(0, -1, 2000);
        exp_pos = exp_pos + 32'd1;
        vecs++;
        if (ecnt !== 1 || etime[0] !== acc2 + 1024 || eab[0] !== 2'b00 || epos[0] !== exp_pos) begin
            errs++; $display("FAIL b2b_second got n=%0d t=%0d ab=%b pos=%h exp n=1 t=1024 ab=00 pos=%h",
                             ecnt, etime[0] - acc2, eab[0], epos[0], exp_pos);
        end
    endtask

    task automatic test_reset_mid_move();
        int acc;
        int dn;
        send_cmd(1'b1, 16'd5, 16'd1024, acc);
        repeat (1500) @(posedge clk);
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        vecs++;
        if ({ch_a, ch_b, busy, done, cmd_ready} !== 5'b00001 || position !== 32'd0) begin
            errs++; $display("FAIL rstmid_state got ab/busy/done/ready=%b pos=%h exp 00001 pos=0",
                             {ch_a, ch_b, busy, done, cmd_ready}, position);
        end
        @(negedge clk); rst = 1'b0;
        dn = 0;
        for (int n = 0; n < 1200; n++) begin
            @(posedge clk); #1;
            if (done || {ch_a, ch_b} !== 2'b00) dn++;
        end
        vecs++;
        if (dn !== 0) begin
            errs++; $display("FAIL rstmid_quiet got activity=%0d exp=0", dn);
        end
    endtask

    initial begin
        logic [31:0] exp_pos;
        exp_pos = 32'd0;
        test_reset();
        test_fwd_basic(exp_pos);
        test_back_clamp(exp_pos);
        test_wrap(exp_pos);
        test_continuous_abort(exp_pos);
        test_abort_on_edge(exp_pos);
        test_back_to_back(exp_pos);
        test_reset_mid_move();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
`default_nettype wire
